fll_cfg_seq: RTL and testbench

- Configuration sequencer directly upstream of fll_top; runs on the FLL reference clock.
- Accepts a requested frequency range from the chip-config/JTAG side and drives fll_bypass, fll_opmode, fll_cfgreq and fll_range into fll_top.
- Synchronises fll_lock back, checks lock with a stability window and a timeout, and only then releases bypass.
- Also watches for loss of lock during normal running.

---
 rtl/fll_cfg_seq.sv | 188 ++++++++++++++++++
 tb/tb_fll_cfg_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_seq.sv
// ---------------------------------------------------------------------------
// fll_cfg_seq : FLL configuration sequencer (bypass / cfgreq / lock checking)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fll_cfg_seq #(
  parameter int unsigned CFGREQ_CYCLES = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_STABLE   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter bit          AUTO_BYPASS   = 1'b1
) (
  input  logic       fll_ref_clk,
  input  logic       fll_rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_range,
  output logic       req_ready,
  input  logic       fll_lock,
  output logic       fll_bypass,
  output logic       fll_opmode,
  output logic       fll_cfgreq,
  output logic [3:0] fll_range,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       lock_lost
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [3:0]  C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  C_CFGREQ_LAST = 4'(CFGREQ_CYCLES - 1);
  localparam logic [7:0]  C_STABLE_LAST = 8'(LOCK_STABLE - 1);
  localparam logic [15:0] C_TOUT_LAST   = 16'(LOCK_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] tout_q, tout_d;
  logic [1:0]  sync_q;
  logic        bypass_q, bypass_d;
  logic        cfgreq_q, cfgreq_d;
  logic [3:0]  range_q, range_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        lost_q, lost_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        lock_s;
  logic        accept;

  assign lock_s = sync_q[1];
  assign accept = req_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stab_d   = stab_q;
    tout_d   = tout_q;
    bypass_d = bypass_q;
    cfgreq_d = cfgreq_q;
    range_d  = range_q;
    done_d   = 1'b0;
    err_d    = err_q;
    lost_d   = lost_q;

    case (state_q)
      S_IDLE, S_ERR: ;
      S_SETTLE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          state_d  = S_REQ;
          cnt_d    = 4'd0;
          cfgreq_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_REQ: begin
        if (cnt_q == C_CFGREQ_LAST) begin
          state_d  = S_WAIT;
          cnt_d    = 4'd0;
          cfgreq_d = 1'b0;
          stab_d   = 8'd0;
          tout_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        tout_d = tout_q + 16'd1;
        stab_d = lock_s ? stab_q + 8'd1 : 8'd0;
        // A stable lock wins over a simultaneous timeout.
        if (lock_s && (stab_q == C_STABLE_LAST)) begin
          state_d  = S_RUN;
          bypass_d = 1'b0;
          done_d   = 1'b1;
          stab_d   = 8'd0;
          tout_d   = 16'd0;
        end else if (tout_q == C_TOUT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          stab_d  = 8'd0;
          tout_d  = 16'd0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost_d = 1'b1;
          if (AUTO_BYPASS) begin
            bypass_d = 1'b1;
            state_d  = S_WAIT;
            stab_d   = 8'd0;
            tout_d   = 16'd0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        bypass_d = 1'b1;
        cfgreq_d = 1'b0;
      end
    endcase

    if (accept) begin
      state_d  = S_SETTLE;
      cnt_d    = 4'd0;
      range_d  = req_range;
      bypass_d = 1'b1;
      err_d    = 1'b0;
      lost_d   = 1'b0;
    end

    // Handshake/status flags are registered from the next state.
    ready_d = (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_ERR);
    busy_d  = !ready_d;
  end

  always_ff @(posedge fll_ref_clk or negedge fll_rst_n) begin
    if (!fll_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      stab_q   <= 8'd0;
      tout_q   <= 16'd0;
      sync_q   <= 2'b00;
      bypass_q <= 1'b1;
      cfgreq_q <= 1'b0;
      range_q  <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stab_q   <= stab_d;
      tout_q   <= tout_d;
      sync_q   <= {sync_q[0], fll_lock};
      bypass_q <= bypass_d;
      cfgreq_q <= cfgreq_d;
      range_q  <= range_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready  = ready_q;
  assign fll_bypass = bypass_q;
  assign fll_opmode = 1'b1;
  assign fll_cfgreq = cfgreq_q;
  assign fll_range  = range_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign lock_lost  = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_fll_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_fll_cfg_seq : directed table + sequence bench for fll_cfg_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fll_cfg_seq;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_range;
  logic       fll_lock;

  logic       a_ready, a_bypass, a_opmode, a_cfgreq, a_busy, a_done, a_err, a_lost;
  logic [3:0] a_range;
  logic       b_ready, b_bypass, b_opmode, b_cfgreq, b_busy, b_done, b_err, b_lost;
  logic [3:0] b_range;

  int n_tests;
  int n_fail;

  fll_cfg_seq #(.AUTO_BYPASS(1'b1)) u_dut (
    .fll_ref_clk(clk), .fll_rst_n(rst_n),
    .req_valid(req_valid), .req_range(req_range), .req_ready(a_ready),
    .fll_lock(fll_lock), .fll_bypass(a_bypass), .fll_opmode(a_opmode),
    .fll_cfgreq(a_cfgreq), .fll_range(a_range), .busy(a_busy),
    .done(a_done), .err(a_err), .lock_lost(a_lost)
  );

  fll_cfg_seq #(.AUTO_BYPASS(1'b0)) u_dut_nab (
    .fll_ref_clk(clk), .fll_rst_n(rst_n),
    .req_valid(req_valid), .req_range(req_range), .req_ready(b_ready),
    .fll_lock(fll_lock), .fll_bypass(b_bypass), .fll_opmode(b_opmode),
    .fll_cfgreq(b_cfgreq), .fll_range(b_range), .busy(b_busy),
    .done(b_done), .err(b_err), .lock_lost(b_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] rng;
    logic       lk;
    logic       byp;
    logic       cfg;
    logic [3:0] frng;
    logic       dn;
    logic       bsy;
    logic       rdy;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic v, logic [3:0] rng, logic lk, logic byp, logic cfg,
                              logic [3:0] frng, logic dn, logic bsy, logic rdy);
    vec_t r;
    r.v = v; r.rng = rng; r.lk = lk; r.byp = byp; r.cfg = cfg;
    r.frng = frng; r.dn = dn; r.bsy = bsy; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies a one-cycle request and returns after the accepting edge.
  task automatic request(input logic [3:0] rng);
    req_valid = 1'b1;
    req_range = rng;
    tick();
    req_valid = 1'b0;
  endtask

  // Counts edges until done (or err) rises; returns -1 on an expired bound.
  task automatic wait_flag(input bit use_err, input int limit, output int n, output bit saw_cfg);
    n = -1;
    saw_cfg = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (a_cfgreq) saw_cfg = 1'b1;
      if ((use_err ? a_err : a_done) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int  n;
    bit  sc;
    int  first_done;

    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_range = 4'd0;
    fll_lock  = 1'b0;

    // Scenario 1 table: request range 7, busy request ignored, then lock.
    tbl[0] = mk(1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    tbl[1] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    tbl[2] = mk(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i <= 6; i++)
      tbl[i] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    tbl[7] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    for (int i = 8; i <= 24; i++)
      tbl[i] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    tbl[25] = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
    tbl[26] = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bypass", a_bypass, 1'b1);
    chk("rst_opmode", a_opmode, 1'b1);
    chk("rst_cfgreq", a_cfgreq, 1'b0);
    chk("rst_range", a_range, 4'd0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_lost", a_lost, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 27; i++) begin
      req_valid = tbl[i].v;
      req_range = tbl[i].rng;
      fll_lock  = tbl[i].lk;
      tick();
      chk($sformatf("t%0d_bypass", i), a_bypass, tbl[i].byp);
      chk($sformatf("t%0d_cfgreq", i), a_cfgreq, tbl[i].cfg);
      chk($sformatf("t%0d_range", i), a_range, tbl[i].frng);
      chk($sformatf("t%0d_done", i), a_done, tbl[i].dn);
      chk($sformatf("t%0d_busy", i), a_busy, tbl[i].bsy);
      chk($sformatf("t%0d_ready", i), a_ready, tbl[i].rdy);
    end
    req_valid = 1'b0;

    // Scenario 2: re-range from RUN with lock held high all along.
    request(4'd8);
    chk("rr_bypass", a_bypass, 1'b1);
    chk("rr_range", a_range, 4'd8);
    repeat (3) tick();
    chk("rr_cfg_pre", a_cfgreq, 1'b0);
    tick();
    chk("rr_cfg_on", a_cfgreq, 1'b1);
    repeat (3) tick();
    chk("rr_cfg_off", a_cfgreq, 1'b0);
    wait_flag(1'b0, 100, n, sc);
    chk("rr_done_lat", n, 16);
    chk("rr_run_bypass", a_bypass, 1'b0);

    // Scenario 3: one-cycle lock drop in RUN, both AUTO_BYPASS flavours.
    fll_lock = 1'b0;
    tick();
    fll_lock = 1'b1;
    tick();
    chk("ll_lost_early", a_lost, 1'b0);
    tick();
    chk("ll_lost_a", a_lost, 1'b1);
    chk("ll_bypass_a", a_bypass, 1'b1);
    chk("ll_busy_a", a_busy, 1'b1);
    chk("ll_lost_b", b_lost, 1'b1);
    chk("ll_bypass_b", b_bypass, 1'b0);
    chk("ll_busy_b", b_busy, 1'b0);
    wait_flag(1'b0, 100, n, sc);
    chk("ll_relock_lat", n, 16);
    chk("ll_no_cfgreq", sc, 1'b0);
    chk("ll_lost_sticky", a_lost, 1'b1);
    chk("ll_bypass_run", a_bypass, 1'b0);

    // Scenario 4: glitchy lock (10 high, 1 low, then high).
    fll_lock = 1'b0;
    request(4'd2);
    chk("gl_lost_clr", a_lost, 1'b0);
    repeat (7) tick();
    first_done = -1;
    for (int t = 1; t <= 40; t++) begin
      fll_lock = (t == 11) ? 1'b0 : 1'b1;
      tick();
      if (a_done === 1'b1 && first_done < 0) first_done = t;
    end
    chk("gl_done_lat", first_done, 29);

    // Scenario 5: lock never rises -> timeout into ERR, then recovery.
    fll_lock = 1'b0;
    request(4'd5);
    wait_flag(1'b1, 5000, n, sc);
    chk("to_err_lat", n, 4103);
    chk("to_err", a_err, 1'b1);
    chk("to_bypass", a_bypass, 1'b1);
    chk("to_ready", a_ready, 1'b1);
    chk("to_busy", a_busy, 1'b0);
    tick();
    chk("to_err_sticky", a_err, 1'b1);
    request(4'd9);
    chk("to_err_clr", a_err, 1'b0);
    chk("to_busy2", a_busy, 1'b1);
    chk("to_range", a_range, 4'd9);

    // Scenario 6: asynchronous reset while cfgreq is high.
    repeat (4) tick();
    chk("ar_cfg_on", a_cfgreq, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_cfgreq", a_cfgreq, 1'b0);
    chk("ar_bypass", a_bypass, 1'b1);
    chk("ar_range", a_range, 4'd0);
    chk("ar_busy", a_busy, 1'b0);
    chk("ar_ready", a_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
